// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port DMEM between the CPU port (m0)
// and a secondary master (m1) that may hold a bounded burst lock.
module dmem_arbiter #(
    parameter int DWIDTH    = 32,
    parameter int AWIDTH    = 10,
    parameter int MAX_BURST = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                m0_req,
    input  logic [DWIDTH/8-1:0] m0_wbe,
    input  logic [AWIDTH-1:0]   m0_addr,
    input  logic [DWIDTH-1:0]   m0_wdata,
    output logic                m0_gnt,
    output logic                m0_rvalid,
    output logic [DWIDTH-1:0]   m0_rdata,
    input  logic                m1_req,
    input  logic                m1_lock,
    input  logic [DWIDTH/8-1:0] m1_wbe,
    input  logic [AWIDTH-1:0]   m1_addr,
    input  logic [DWIDTH-1:0]   m1_wdata,
    output logic                m1_gnt,
    output logic                m1_rvalid,
    output logic [DWIDTH-1:0]   m1_rdata,
    output logic                mem_en,
    output logic [DWIDTH/8-1:0] mem_wbe,
    output logic [AWIDTH-1:0]   mem_addr,
    output logic [DWIDTH-1:0]   mem_din,
    input  logic [DWIDTH-1:0]   mem_dout
);

    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] BURST_MAX = CW'(MAX_BURST);

    logic          last_gnt_q, last_gnt_d;     // 1: m1 won the most recent grant
    logic          m1_prev_q, m1_prev_d;
    logic [CW-1:0] burst_cnt_q, burst_cnt_d;
    logic          rd_pending_q, rd_pending_d;
    logic          rd_owner_q, rd_owner_d;
    logic          lock_active;

    always_comb begin
        lock_active = m1_lock && m1_prev_q && (burst_cnt_q < BURST_MAX);
        m0_gnt = 1'b0;
        m1_gnt = 1'b0;
        // Grants are forced off while reset is held, without waiting for a clock.
        if (rst) begin
            if (m0_req && m1_req) begin
                if (lock_active)     m1_gnt = 1'b1;
                else if (last_gnt_q) m0_gnt = 1'b1;
                else                 m1_gnt = 1'b1;
            end else if (m0_req) begin
                m0_gnt = 1'b1;
            end else if (m1_req) begin
                m1_gnt = 1'b1;
            end
        end

        mem_en   = m0_gnt | m1_gnt;
        mem_wbe  = '0;
        mem_addr = '0;
        mem_din  = '0;
        if (m0_gnt) begin
            mem_wbe  = m0_wbe;
            mem_addr = m0_addr;
            mem_din  = m0_wdata;
        end else if (m1_gnt) begin
            mem_wbe  = m1_wbe;
            mem_addr = m1_addr;
            mem_din  = m1_wdata;
        end
    end

    always_comb begin
        last_gnt_d = last_gnt_q;
        if (m0_gnt)      last_gnt_d = 1'b0;
        else if (m1_gnt) last_gnt_d = 1'b1;

        m1_prev_d = m1_gnt;

        burst_cnt_d = '0;
        if (m1_gnt && m1_lock) begin
            burst_cnt_d = (burst_cnt_q == BURST_MAX) ? burst_cnt_q : burst_cnt_q + CW'(1);
        end

        rd_pending_d = mem_en && (mem_wbe == '0);
        rd_owner_d   = m1_gnt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_gnt_q   <= 1'b1;
            m1_prev_q    <= 1'b0;
            burst_cnt_q  <= '0;
            rd_pending_q <= 1'b0;
            rd_owner_q   <= 1'b0;
        end else begin
            last_gnt_q   <= last_gnt_d;
            m1_prev_q    <= m1_prev_d;
            burst_cnt_q  <= burst_cnt_d;
            rd_pending_q <= rd_pending_d;
            rd_owner_q   <= rd_owner_d;
        end
    end

    // Read data is steered to the owner and zeroed for the other requester.
    always_comb begin
        m0_rvalid = rd_pending_q && !rd_owner_q;
        m1_rvalid = rd_pending_q &&  rd_owner_q;
        m0_rdata  = m0_rvalid ? mem_dout : '0;
        m1_rdata  = m1_rvalid ? mem_dout : '0;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed stimulus pushes expected grants
// and read responses; a negedge monitor pops and compares them.
module tb_dmem_arbiter;

    logic        clk;
    logic        rst;
    logic        m0_req, m1_req, m1_lock;
    logic [3:0]  m0_wbe, m1_wbe;
    logic [9:0]  m0_addr, m1_addr;
    logic [31:0] m0_wdata, m1_wdata;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        mem_en;
    logic [3:0]  mem_wbe;
    logic [9:0]  mem_addr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;

    dmem_arbiter #(.DWIDTH(32), .AWIDTH(10), .MAX_BURST(4)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_wbe(m0_wbe), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_lock(m1_lock), .m1_wbe(m1_wbe), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_en(mem_en), .mem_wbe(mem_wbe), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_dout(mem_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        bit          who;
        logic [3:0]  wbe;
        logic [9:0]  addr;
        logic [31:0] d;
    } gexp_t;

    typedef struct {
        int          cyc;
        bit          who;
        logic [31:0] d;
    } rexp_t;

    gexp_t gq[$];
    rexp_t rq[$];
    int    n_cmp = 0;
    int    n_fail = 0;
    int    cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Single-port DMEM model with one-cycle read latency.
    logic [31:0] mem [0:1023];
    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[1]     = 32'h1111_0001;
        mem[2]     = 32'h2222_0002;
        mem[5]     = 32'hAAAA_AAAA;
        mem[10'h10] = 32'hDEAD_BEEF;
        mem_dout   = 32'h0;
    end
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_wbe == 4'b0000) mem_dout <= mem[mem_addr];
            else for (int b = 0; b < 4; b++)
                if (mem_wbe[b]) mem[mem_addr][8*b +: 8] <= mem_din[8*b +: 8];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: got event, want none (cycle %0d)", name, cyc);
    endtask

    task automatic exp_g(input bit who, input logic [3:0] wbe, input logic [9:0] addr,
                         input logic [31:0] d);
        gq.push_back('{cyc, who, wbe, addr, d});
    endtask

    task automatic exp_r(input bit who, input logic [31:0] d);
        rq.push_back('{cyc + 1, who, d});
    endtask

    task automatic drive(input logic r0, input logic [3:0] w0, input logic [9:0] a0,
                         input logic [31:0] d0, input logic r1, input logic l1,
                         input logic [3:0] w1, input logic [9:0] a1, input logic [31:0] d1);
        @(posedge clk);
        #1;
        m0_req = r0; m0_wbe = w0; m0_addr = a0; m0_wdata = d0;
        m1_req = r1; m1_lock = l1; m1_wbe = w1; m1_addr = a1; m1_wdata = d1;
    endtask

    task automatic idle();
        drive(0, 4'h0, 10'h0, 32'h0, 0, 0, 4'h0, 10'h0, 32'h0);
    endtask

    // Monitor
    always @(negedge clk) begin
        gexp_t g;
        rexp_t r;
        if (m0_gnt && m1_gnt) flag("gnt_both");
        if (mem_en) begin
            if (gq.size() == 0) flag("gnt_unexpected");
            else begin
                g = gq.pop_front();
                check("gnt_cycle", 64'(cyc), 64'(g.cyc));
                check("gnt_who", {63'h0, m1_gnt}, {63'h0, g.who});
                check("gnt_m0", {63'h0, m0_gnt}, {63'h0, !g.who});
                check("mem_wbe", 64'(mem_wbe), 64'(g.wbe));
                check("mem_addr", 64'(mem_addr), 64'(g.addr));
                check("mem_din", 64'(mem_din), 64'(g.d));
            end
        end else begin
            check("idle_gnt", {62'h0, m0_gnt, m1_gnt}, 64'h0);
            check("idle_mem", {mem_wbe, mem_addr, mem_din}, 64'h0);
        end
        if (m0_rvalid || m1_rvalid) begin
            if (m0_rvalid && m1_rvalid) flag("rvalid_both");
            else if (rq.size() == 0) flag("rvalid_unexpected");
            else begin
                r = rq.pop_front();
                check("rv_cycle", 64'(cyc), 64'(r.cyc));
                check("rv_who", {63'h0, m1_rvalid}, {63'h0, r.who});
                check("rdata", 64'(r.who ? m1_rdata : m0_rdata), 64'(r.d));
                check("rdata_other", 64'(r.who ? m0_rdata : m1_rdata), 64'h0);
            end
        end else begin
            check("idle_rdata", {m0_rdata, m1_rdata}, 64'h0);
        end
    end

    int burst_exp [7] = '{1, 1, 1, 1, 0, 1, 1};

    initial begin
        rst = 1'b0;
        m0_req = 1; m0_wbe = 4'h0; m0_addr = 10'h1; m0_wdata = 32'h0;
        m1_req = 1; m1_lock = 0; m1_wbe = 4'h0; m1_addr = 10'h2; m1_wdata = 32'h0;

        // Reset held with both requesting
        repeat (3) begin
            @(negedge clk);
            check("rst_gnt", {62'h0, m0_gnt, m1_gnt}, 64'h0);
            check("rst_mem_en", {63'h0, mem_en}, 64'h0);
            check("rst_mem_wbe", 64'(mem_wbe), 64'h0);
            check("rst_rvalid", {62'h0, m0_rvalid, m1_rvalid}, 64'h0);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_g(0, 4'h0, 10'h1, 32'h0); exp_r(0, 32'h1111_0001);
        drive(0, 4'h0, 10'h0, 32'h0, 1, 0, 4'h0, 10'h2, 32'h0);
        exp_g(1, 4'h0, 10'h2, 32'h0); exp_r(1, 32'h2222_0002);
        idle();

        // Round-robin writes
        for (int i = 0; i < 6; i++) begin
            drive(1, 4'hF, 10'h20, 32'hA0A0_A0A0, 1, 0, 4'hF, 10'h30, 32'hB0B0_B0B0);
            if (i % 2 == 0) exp_g(0, 4'hF, 10'h20, 32'hA0A0_A0A0);
            else            exp_g(1, 4'hF, 10'h30, 32'hB0B0_B0B0);
        end
        idle();

        // Single read
        drive(1, 4'h0, 10'h10, 32'h0, 0, 0, 4'h0, 10'h0, 32'h0);
        exp_g(0, 4'h0, 10'h10, 32'h0); exp_r(0, 32'hDEAD_BEEF);
        idle();

        // Burst lock against a waiting m0
        for (int i = 0; i < 7; i++) begin
            drive(1, 4'hF, 10'h40, 32'h4040_4040, 1, 1, 4'hF, 10'h41, 32'h4141_4141);
            if (burst_exp[i] == 1) exp_g(1, 4'hF, 10'h41, 32'h4141_4141);
            else                   exp_g(0, 4'hF, 10'h40, 32'h4040_4040);
        end
        idle();

        // m1 alone beyond MAX_BURST, then m0 arrives with the counter saturated
        for (int i = 0; i < 6; i++) begin
            drive(0, 4'h0, 10'h0, 32'h0, 1, 1, 4'hF, 10'h42, 32'h4242_4242);
            exp_g(1, 4'hF, 10'h42, 32'h4242_4242);
        end
        drive(1, 4'hF, 10'h43, 32'h4343_4343, 1, 1, 4'hF, 10'h42, 32'h4242_4242);
        exp_g(0, 4'hF, 10'h43, 32'h4343_4343);
        idle();

        // Partial write by m1, read back by m0
        drive(0, 4'h0, 10'h0, 32'h0, 1, 0, 4'h3, 10'h5, 32'h1234_5678);
        exp_g(1, 4'h3, 10'h5, 32'h1234_5678);
        drive(1, 4'h0, 10'h5, 32'h0, 0, 0, 4'h0, 10'h0, 32'h0);
        exp_g(0, 4'h0, 10'h5, 32'h0); exp_r(0, 32'hAAAA_5678);
        idle();

        // Reset asserted while an m1 read response is due
        drive(0, 4'h0, 10'h0, 32'h0, 1, 0, 4'h0, 10'h2, 32'h0);
        exp_g(1, 4'h0, 10'h2, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        m1_req = 0;
        @(negedge clk);
        check("rst_mid_rvalid", {63'h0, m1_rvalid}, 64'h0);
        check("rst_mid_rdata", 64'(m1_rdata), 64'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // First tie after reset goes to m0
        drive(1, 4'h0, 10'h10, 32'h0, 1, 0, 4'h0, 10'h1, 32'h0);
        exp_g(0, 4'h0, 10'h10, 32'h0); exp_r(0, 32'hDEAD_BEEF);
        drive(0, 4'h0, 10'h0, 32'h0, 1, 0, 4'h0, 10'h1, 32'h0);
        exp_g(1, 4'h0, 10'h1, 32'h0); exp_r(1, 32'h1111_0001);
        repeat (3) idle();

        @(negedge clk);
        #1;
        check("gnt_queue_left", 64'(gq.size()), 64'h0);
        check("rv_queue_left", 64'(rq.size()), 64'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter sharing the single-port data memory between the CPU load/store port (requester 0) and a secondary master such as the UART program loader or a debug port (requester 1). It sits between the requesters and the DMEM instance and drives its enable, byte write-enable, address and write-data inputs. It routes the one-cycle-latency read data back to whichever requester issued the read. Arbitration is round-robin, with a bounded burst lock for requester 1.

## Interface
- DWIDTH, 32, data width; byte write-enable width is DWIDTH/8
- AWIDTH, 10, word address width of DMEM
- MAX_BURST, 4, maximum consecutive locked grants to requester 1 while requester 0 waits (≥1)
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset; asynchronous, active-low
- m0_req  in  1  requester 0 access request; held until granted
- m0_wbe  in  DWIDTH/8  byte write enables; all-zero means read
- m0_addr  in  AWIDTH  word address
- m0_wdata  in  DWIDTH  write data
- m0_gnt  out  1  access accepted this cycle
- m0_rvalid  out  1  read data valid for requester 0
- m0_rdata  out  DWIDTH  read data
- m1_req, m1_wbe, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata  same as m0_*, for requester 1
- m1_lock  in  1  requester 1 requests back-to-back ownership (burst)
- mem_en  out  1  DMEM enable
- mem_wbe  out  DWIDTH/8  DMEM byte write enables
- mem_addr  out  AWIDTH  DMEM word address
- mem_din  out  DWIDTH  DMEM write data
- mem_dout  in  DWIDTH  DMEM read data; valid one cycle after an enabled read

## Operation
- Grant decision is combinational from the current requests and registered state. At most one of m0_gnt or m1_gnt is high in any cycle.
- Only one requester active: that requester is granted.
- Both requesting, lock active: requester 1 is granted. Lock is active when:
  - m1_lock is high, and
  - requester 1 was granted in the previous cycle, and
  - burst_cnt < MAX_BURST.
- Both requesting, lock not active: round-robin. The requester not granted last (last_gnt register) wins.
- burst_cnt (width clog2(MAX_BURST+1)):
  - increments, saturating at MAX_BURST, on each cycle m1 is granted with m1_lock high;
  - clears on any cycle m1 is not granted or m1_lock is low.
- When burst_cnt = MAX_BURST and m0_req is high, requester 0 gets the next grant. After that, lock may re-engage.
- If requester 0 is idle, requester 1 keeps its grant regardless of burst_cnt.
- last_gnt updates only on cycles with a grant.
- Granted cycle: mem_en=1, and mem_wbe/mem_addr/mem_din are the winner's fields.
- No grant: mem_en=0, mem_wbe=0, mem_addr=0, mem_din=0.
- Read = granted access with wbe all-zero. The arbiter registers rd_pending=1 and rd_owner=winner.
- Next cycle: the owner's rvalid is 1 and its rdata = mem_dout. The other requester's rvalid is 0 and its rdata is 0.
- Writes produce no rvalid.
- Back-to-back reads from alternating requesters are legal. Each rvalid follows its own grant by exactly one cycle.
- Requester contract (not checked by the arbiter):
  - request fields stay stable while req is high and gnt is low;
  - deasserting req before grant is allowed and cancels the request.

## Timing
- Grant latency: 0 cycles. gnt is asserted in the same cycle as req when that requester wins.
- Read latency: rvalid exactly 1 cycle after the granted cycle.
- Throughput: one access per cycle, no bubbles between requesters.
- Reset (rst low, asynchronous), all effective immediately:
  - m0_gnt=m1_gnt=0;
  - m0_rvalid=m1_rvalid=0 and rdata=0;
  - mem_en=0, mem_wbe=0;
  - last_gnt=1, so requester 0 wins the first tie;
  - burst_cnt=0, rd_pending=0.
- A read granted in the cycle before reset asserts produces no rvalid.
- Simultaneous read response and new grant in the same cycle: both are served, with no interaction.
- Deassertion of rst is synchronized by the system. The first grant can occur in the first cycle after rst goes high.

## Test plan
- Reset: hold rst=0 with both req=1 → gnt=0, mem_en=0, rvalid=0. Release with both requesting → m0_gnt=1 first, m1_gnt=1 next cycle.
- Single read: m0 reads addr 0x010, memory holds 0xDEADBEEF → m0_gnt and mem_en high in cycle N; m0_rvalid=1 with m0_rdata=0xDEADBEEF in cycle N+1; m1_rvalid=0.
- Round-robin: both requesters hold req=1 for 6 cycles with m1_lock=0 → grants alternate 0,1,0,1,0,1; mem_addr follows the winner each cycle.
- Burst lock: MAX_BURST=4, m1 granted with m1_lock=1, m0_req continuously high → m1 granted 4 consecutive cycles, then m0 once, then m1 resumes.
- Interleaved reads and writes: m1 writes 0x12345678 with wbe=4'b0011 to addr 5, then m0 reads addr 5 → mem_wbe=4'b0011 on the write cycle; m0_rdata low half = 0x5678; only m0_rvalid pulses.
- Reset mid-read: assert rst in the cycle after a granted m1 read → m1_rvalid drops to 0 immediately; after release, there is no spurious rvalid.
